ceespu_bp_table_ctrl: RTL
=========================

Name: ceespu_bp_table_ctrl

Overview:
Sequences all writes into the branch predictor's 2-bit counter table.
- After reset, or on request, it runs a clear sweep that initialises every entry.
- In normal operation it buffers resolved-branch updates from execute in a small FIFO.
- It computes the saturating next counter state and drains each update into the single table port, yielding to fetch-stage lookups.
- It sits between execute (branch resolution) and the predictor table write port.

Parameters:
INDEX_BITS, 6, log2 of table entries (64 entries)
FIFO_DEPTH, 4, update queue depth; power of 2, at least 2
INIT_STATE, 2'b01, counter value written by a clear sweep (weakly not-taken)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = in reset)
I_upd_valid  in  1  resolved branch update offered
O_upd_ready  out  1  queue can accept an update
I_upd_address  in  16  branch instruction address
I_upd_state  in  2  prediction_state the predictor returned for this branch
I_upd_taken  in  1  actual branch outcome
I_fetch_lookup  in  1  fetch is reading the table this cycle; the port is busy
I_clear  in  1  request a table re-initialisation sweep
O_tbl_we  out  1  table write enable
O_tbl_index  out  INDEX_BITS  table write index
O_tbl_wdata  out  2  table write data
O_init_busy  out  1  a clear sweep is in progress; predictions are invalid
O_queue_count  out  log2(FIFO_DEPTH)+1  number of queued updates

Behaviour:
Reset (rst=0, asynchronous):
- State goes to S_CLEAR, sweep counter to 0, FIFO empties.
- Outputs forced while rst=0: O_tbl_we=0, O_upd_ready=0, O_init_busy=1, O_queue_count=0, O_tbl_index=0, O_tbl_wdata=0.

Update queue:
- Index = I_upd_address[INDEX_BITS-1:0]. Addresses are word-indexed; upper bits alias.
- Handshake: push when I_upd_valid && O_upd_ready at a rising edge.
- O_upd_ready = !full && rst. This is independent of FSM state, so updates are accepted during a sweep.
- Each entry stores {index, I_upd_state, I_upd_taken}.
- Push and pop in the same cycle leaves the count unchanged. No push when full; ready is low.

Next-state arithmetic (on FIFO head):
- taken: min(state+1, 3).
- not taken: max(state-1, 0).
- Saturation: 3 stays 3, 0 stays 0.
- Each entry uses its own captured state. There is no merging or forwarding between entries for the same index; the last write wins.

FSM, two states:
- S_CLEAR:
  - O_tbl_we=1, O_tbl_index=sweep counter, O_tbl_wdata=INIT_STATE, O_init_busy=1.
  - Writes every cycle, ignoring I_fetch_lookup. Fetch treats predictions as not-taken while O_init_busy=1.
  - The counter increments each cycle. After writing index 2^INDEX_BITS-1, the next state is S_RUN with the counter reset to 0.
  - The sweep lasts exactly 2^INDEX_BITS cycles.
  - I_clear is ignored in S_CLEAR.
  - The queue does not drain in S_CLEAR.
- S_RUN:
  - O_init_busy=0.
  - O_tbl_we = !empty && !I_fetch_lookup. When high: O_tbl_index = head index, O_tbl_wdata = next-state of head, and the head pops at the same edge.
  - O_tbl_we/index/wdata are combinational from the head and I_fetch_lookup.
  - When O_tbl_we=0: index=0, wdata=0.
  - I_clear=1 moves to S_CLEAR at the next edge. If I_clear and a drain coincide, the drain write completes that cycle.
  - Queued entries are preserved across the sweep and drain after it.

Latency:
- An update pushed at edge N is visible at the head after N. The earliest write is the cycle following N, given S_RUN and no lookup.

Starvation:
- Continuous I_fetch_lookup stalls drains indefinitely. Ready drops at full; there is no forced write.

Test Plan:
1. Release rst, hold I_fetch_lookup=0 -> O_init_busy=1 and O_tbl_we=1 for 64 cycles with index 0..63 and wdata 01; the next cycle busy=0 and we=0.
2. In S_RUN push addr 60, state 01, taken=1 -> next cycle we=1, index 60, wdata 10, count back to 0. Push state 11 taken -> wdata 11. Push state 00 not-taken -> wdata 00. Push state 10 not-taken -> wdata 01.
3. Hold I_fetch_lookup=1 and push 4 updates (addr 1,2,3,4) -> count=4, ready=0, we=0. Release lookup -> 4 consecutive writes to index 1,2,3,4 in order, then ready=1.
4. Push addr 16'h0043 -> index 3. Push 16'hFFC5 -> index 5.
5. With 2 entries queued and lookup=1, pull rst low mid-cycle -> we=0 and count=0 immediately. On release, a full 64-cycle sweep runs and no stale writes follow.
6. In S_RUN with 3 entries queued under lookup=1, pulse I_clear and release lookup -> 64-cycle sweep, then the 3 queued writes drain in order; count ends at 0.

Source files
------------

// File: rtl/ceespu_bp_table_ctrl_if.sv
// Execute-side update channel, fetch lookup/clear controls and the predictor table write port
// for the 2-bit counter table controller.
interface ceespu_bp_table_ctrl_if #(
    parameter int INDEX_BITS = 6,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [15:0]           upd_address;
    logic [1:0]            upd_state;
    logic                  upd_taken;
    logic                  fetch_lookup;
    logic                  clear;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_index;
    logic [1:0]            tbl_wdata;
    logic                  init_busy;
    logic [CNT_BITS-1:0]   queue_count;

    modport master (
        output upd_valid, upd_address, upd_state, upd_taken, fetch_lookup, clear,
        input  upd_ready, tbl_we, tbl_index, tbl_wdata, init_busy, queue_count
    );

    modport slave (
        input  upd_valid, upd_address, upd_state, upd_taken, fetch_lookup, clear,
        output upd_ready, tbl_we, tbl_index, tbl_wdata, init_busy, queue_count
    );
endinterface

// File: rtl/ceespu_bp_table_ctrl.sv
// Branch predictor table write sequencer: clear sweep after reset/request, then drains
// queued resolved-branch updates as saturating 2-bit counter writes when fetch is idle.
//
// state   | meaning
// S_CLEAR | writing INIT_STATE to every entry, one per cycle; predictions invalid
// S_RUN   | draining the update queue into the table whenever fetch is not reading it
module ceespu_bp_table_ctrl #(
    parameter int         INDEX_BITS = 6,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input logic                   clk,
    input logic                   rst_n,
    ceespu_bp_table_ctrl_if.slave bus
);
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int ENTRY_BITS = INDEX_BITS + 3;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_q, sweep_d;

    logic [ENTRY_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0]   count_q;
    logic                  full, empty, ready, push, pop;

    logic [ENTRY_BITS-1:0] head;
    logic [INDEX_BITS-1:0] head_index;
    logic [1:0]            head_state, head_next;
    logic                  head_taken;

    logic                  we;
    logic [INDEX_BITS-1:0] wr_index;
    logic [1:0]            wr_data;
    logic                  busy;

    assign full  = (count_q == CNT_BITS'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign ready = !full && rst_n;
    assign push  = bus.upd_valid && ready;

    assign head       = fifo_mem[rd_ptr_q];
    assign head_index = head[ENTRY_BITS-1:3];
    assign head_state = head[2:1];
    assign head_taken = head[0];

    always_comb begin
        head_next = head_state;
        if (head_taken) begin
            if (head_state != 2'b11) head_next = head_state + 2'b01;
        end else begin
            if (head_state != 2'b00) head_next = head_state - 2'b01;
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        we       = 1'b0;
        wr_index = '0;
        wr_data  = 2'b00;
        busy     = 1'b1;
        pop      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                we       = 1'b1;
                wr_index = sweep_q;
                wr_data  = INIT_STATE;
                sweep_d  = sweep_q + INDEX_BITS'(1);
                if (&sweep_q) begin
                    state_d = S_RUN;
                    sweep_d = '0;
                end
            end
            S_RUN: begin
                busy = 1'b0;
                if (!empty && !bus.fetch_lookup) begin
                    we       = 1'b1;
                    wr_index = head_index;
                    wr_data  = head_next;
                    pop      = 1'b1;
                end
                if (bus.clear) state_d = S_CLEAR;
            end
            default: begin
                state_d = S_CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once the count says it was written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {bus.upd_address[INDEX_BITS-1:0], bus.upd_state, bus.upd_taken};
    end

    // Reset must silence the table port immediately, not at the next edge.
    assign bus.tbl_we      = we && rst_n;
    assign bus.tbl_index   = rst_n ? wr_index : '0;
    assign bus.tbl_wdata   = rst_n ? wr_data : 2'b00;
    assign bus.init_busy   = busy || !rst_n;
    assign bus.upd_ready   = ready;
    assign bus.queue_count = count_q;
endmodule
